// File: rtl/lsu_subword_ctrl.sv
// Load/store unit: turns RV32I byte/half/word accesses into word-only memory accesses.
// Optional macro MISALIGN_TRAP_EN: misaligned H/W accesses fault instead of being force-aligned.
module lsu_subword_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic              mem_we,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic [31:0]       r_wdata;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wd;
    logic              r_mem_we;

    logic              w_fire;
    logic              w_bad_funct3;
    logic              w_out_of_range;
    logic              w_misaligned;
    logic              w_err;
    logic [1:0]        w_off_eff;
    logic              w_req_ready_nxt;
    logic              w_rsp_valid_nxt;
    logic [31:0]       w_rsp_rdata_nxt;
    logic              w_rsp_err_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [31:0]       w_mem_wd_nxt;
    logic              w_mem_we_nxt;

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return word;
            3'd4:    return {24'h000000, b};
            3'd5:    return {16'h0000, h};
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] m;
        m = old;
        case (f3[1:0])
            2'd0: begin
                case (off)
                    2'd0:    m[7:0]   = wd[7:0];
                    2'd1:    m[15:8]  = wd[7:0];
                    2'd2:    m[23:16] = wd[7:0];
                    2'd3:    m[31:24] = wd[7:0];
                    default: m = old;
                endcase
            end
            2'd1: begin
                if (off[1]) begin
                    m[31:16] = wd[15:0];
                end else begin
                    m[15:0] = wd[15:0];
                end
            end
            default: m = wd;
        endcase
        return m;
    endfunction

    // Request decode: fault classification and the lane offset actually used
    always_comb begin
        w_fire         = req_valid & r_req_ready;
        w_bad_funct3   = req_we ? (req_funct3 >= 3'd3)
                                : ((req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7));
        w_out_of_range = ({2'b00, req_addr[ADDR_W-1:2]} >= ADDR_W'(MEM_WORDS));
`ifdef MISALIGN_TRAP_EN
        w_misaligned   = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
        w_off_eff      = req_addr[1:0];
`else
        w_misaligned   = 1'b0;
        case (req_funct3[1:0])
            2'd1:    w_off_eff = {req_addr[1], 1'b0};
            2'd2:    w_off_eff = 2'b00;
            default: w_off_eff = req_addr[1:0];
        endcase
`endif
        w_err          = w_bad_funct3 | w_out_of_range | w_misaligned;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_fire) begin
                    w_next_state = S_IDLE;
                end else if (w_err) begin
                    w_next_state = S_RESP;
                end else if (!req_we) begin
                    w_next_state = S_LOAD;
                end else if (req_funct3 == 3'd2) begin
                    w_next_state = S_WRITE;
                end else begin
                    w_next_state = S_RMW_RD;
                end
            end
            S_LOAD:   w_next_state = S_RESP;
            S_RMW_RD: w_next_state = S_WRITE;
            S_WRITE:  w_next_state = S_RESP;
            S_RESP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Output logic: next values of every registered output
    always_comb begin
        w_req_ready_nxt = (w_next_state == S_IDLE);
        w_rsp_valid_nxt = (w_next_state == S_RESP);
        w_mem_we_nxt    = (w_next_state == S_WRITE);
        w_rsp_err_nxt   = (r_state == S_IDLE) & w_fire & w_err;
        if (r_state == S_LOAD) begin
            w_rsp_rdata_nxt = load_extend(r_funct3, r_off, mem_rd);
        end else begin
            w_rsp_rdata_nxt = 32'h0000_0000;
        end
        // Address is only driven for real memory accesses; faults leave it at zero
        if (w_next_state == S_IDLE) begin
            w_mem_addr_nxt = '0;
        end else if (r_state == S_IDLE) begin
            w_mem_addr_nxt = w_err ? '0 : {req_addr[ADDR_W-1:2], 2'b00};
        end else begin
            w_mem_addr_nxt = r_mem_addr;
        end
        case (r_state)
            S_IDLE:   w_mem_wd_nxt = (w_next_state == S_WRITE) ? req_wdata : 32'h0000_0000;
            S_RMW_RD: w_mem_wd_nxt = store_merge(r_funct3, r_off, mem_rd, r_wdata);
            default:  w_mem_wd_nxt = 32'h0000_0000;
        endcase
    end

    // Output registers and request capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wd    <= 32'h0000_0000;
            r_mem_we    <= 1'b0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_wdata     <= 32'h0000_0000;
        end else begin
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wd    <= w_mem_wd_nxt;
            r_mem_we    <= w_mem_we_nxt;
            if ((r_state == S_IDLE) && w_fire) begin
                r_funct3 <= req_funct3;
                r_off    <= w_off_eff;
                r_wdata  <= req_wdata;
            end else begin
                r_funct3 <= r_funct3;
                r_off    <= r_off;
                r_wdata  <= r_wdata;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_addr  = r_mem_addr;
    assign mem_wd    = r_mem_wd;
    assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Directed bench for lsu_subword_ctrl with a 4096-word behavioural memory.
module tb_lsu_subword_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:4095];
    int checks = 0;
    int errors = 0;

    lsu_subword_ctrl #(.ADDR_W(32), .MEM_WORDS(4096)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr[13:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[13:2]] <= mem_wd;
        end
    end

    // Issue one request and observe cycles 1..8 after the fire edge
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int rsp_cyc, output logic [31:0] rdata,
                          output logic err, output int we_cnt, output int we_cyc,
                          output logic [31:0] addr_c1, output int rsp_cnt);
        int waitc;
        waitc = 0;
        rsp_cyc = 0; rdata = 32'hDEAD_DEAD; err = 1'bx; we_cnt = 0; we_cyc = 0;
        addr_c1 = 32'hFFFF_FFFF; rsp_cnt = 0;
        @(negedge clk);
        while (!req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, waitc);
        end
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) addr_c1 = mem_addr;
            if (mem_we) begin
                we_cnt++;
                if (we_cyc == 0) we_cyc = k;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_cyc == 0) begin
                    rsp_cyc = k; rdata = rsp_rdata; err = rsp_err;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        #12;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: ready/rvalid/err/we=%b required 0000", {req_ready, rsp_valid, rsp_err, mem_we});
        end
        checks++;
        if ({rsp_rdata, mem_addr, mem_wd} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h addr=%h wd=%h required 0", rsp_rdata, mem_addr, mem_wd);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
        end
    endtask

    task automatic test_load();
        int rc, wc, wcy, rn; logic [31:0] rd, a1; logic e;
        logic [2:0]  f3 [5]  = '{3'd0, 3'd4, 3'd2, 3'd1, 3'd5};
        logic [31:0] ad [5]  = '{32'h103, 32'h101, 32'h100, 32'h100, 32'h102};
        logic [31:0] ex [5]  = '{32'hFFFF_FF88, 32'h0000_00AA, 32'h8899_AABB, 32'hFFFF_AABB, 32'h0000_8899};
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, f3[i], ad[i], 32'h0, rc, rd, e, wc, wcy, a1, rn);
            checks++;
            if (rc !== 2 || rd !== ex[i] || e !== 1'b0 || wc !== 0 || rn !== 1) begin
                errors++;
                $display("FAIL load_%0d: cyc=%0d data=%h err=%b we=%0d rsp=%0d required cyc=2 data=%h err=0 we=0 rsp=1",
                         i, rc, rd, e, wc, rn, ex[i]);
            end
        end
        checks++;
        if (a1 !== 32'h100) begin
            errors++;
            $display("FAIL load_mem_addr: mem_addr=%h required 00000100", a1);
        end
    endtask

    task automatic test_store_byte();
        int rc, wc, wcy, rn; logic [31:0] rd, a1; logic e;
        do_req(1'b1, 3'd0, 32'h102, 32'h1234_5677, rc, rd, e, wc, wcy, a1, rn);
        checks++;
        if (wc !== 1 || wcy !== 2 || rc !== 3 || rd !== 32'h0 || e !== 1'b0) begin
            errors++;
            $display("FAIL sb_timing: we=%0d wecyc=%0d rspcyc=%0d data=%h err=%b required 1 2 3 0 0", wc, wcy, rc, rd, e);
        end
        checks++;
        if (mem[12'h040] !== 32'h8877_AABB) begin
            errors++;
            $display("FAIL sb_word: mem=%h required 8877aabb", mem[12'h040]);
        end
    endtask

    task automatic test_store_half();
        int rc, wc, wcy, rn; logic [31:0] rd, a1; logic e;
        do_req(1'b1, 3'd1, 32'h102, 32'h0000_CAFE, rc, rd, e, wc, wcy, a1, rn);
        checks++;
        if (mem[12'h040] !== 32'hCAFE_AABB || rc !== 3 || wc !== 1) begin
            errors++;
            $display("FAIL sh_word: mem=%h cyc=%0d we=%0d required cafeaabb 3 1", mem[12'h040], rc, wc);
        end
        do_req(1'b0, 3'd1, 32'h102, 32'h0, rc, rd, e, wc, wcy, a1, rn);
        checks++;
        if (rd !== 32'hFFFF_CAFE) begin
            errors++;
            $display("FAIL lh_after_sh: data=%h required ffffcafe", rd);
        end
        do_req(1'b0, 3'd5, 32'h102, 32'h0, rc, rd, e, wc, wcy, a1, rn);
        checks++;
        if (rd !== 32'h0000_CAFE) begin
            errors++;
            $display("FAIL lhu_after_sh: data=%h required 0000cafe", rd);
        end
    endtask

    task automatic test_store_word();
        int rc, wc, wcy, rn; logic [31:0] rd, a1; logic e;
        do_req(1'b1, 3'd2, 32'h108, 32'hDEAD_BEEF, rc, rd, e, wc, wcy, a1, rn);
        checks++;
        if (wc !== 1 || wcy !== 1 || rc !== 2 || mem[12'h042] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw: we=%0d wecyc=%0d rspcyc=%0d mem=%h required 1 1 2 deadbeef", wc, wcy, rc, mem[12'h042]);
        end
    endtask

    task automatic test_errors();
        int rc, wc, wcy, rn; logic [31:0] rd, a1; logic e;
        logic        wev [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3  [4] = '{3'd2, 3'd3, 3'd3, 3'd6};
        logic [31:0] ad  [4] = '{32'h4000, 32'h100, 32'h100, 32'h100};
        for (int i = 0; i < 4; i++) begin
            do_req(wev[i], f3[i], ad[i], 32'hFFFF_FFFF, rc, rd, e, wc, wcy, a1, rn);
            checks++;
            if (e !== 1'b1 || rc !== 1 || wc !== 0 || rd !== 32'h0 || a1 !== 32'h0) begin
                errors++;
                $display("FAIL err_%0d: err=%b cyc=%0d we=%0d data=%h addr=%h required 1 1 0 0 0", i, e, rc, wc, rd, a1);
            end
        end
        checks++;
        if (mem[12'h040] !== 32'hCAFE_AABB) begin
            errors++;
            $display("FAIL err_no_write: mem=%h required cafeaabb", mem[12'h040]);
        end
    endtask

    task automatic test_misalign();
        int rc, wc, wcy, rn; logic [31:0] rd, a1; logic e;
        do_req(1'b0, 3'd2, 32'h105, 32'h0, rc, rd, e, wc, wcy, a1, rn);
        checks++;
`ifdef MISALIGN_TRAP_EN
        if (e !== 1'b1 || rc !== 1 || a1 !== 32'h0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL lw_misalign: err=%b cyc=%0d addr=%h data=%h required 1 1 0 0", e, rc, a1, rd);
        end
`else
        if (e !== 1'b0 || rc !== 2 || a1 !== 32'h104 || rd !== 32'h1122_3344) begin
            errors++;
            $display("FAIL lw_misalign: err=%b cyc=%0d addr=%h data=%h required 0 2 104 11223344", e, rc, a1, rd);
        end
`endif
        do_req(1'b0, 3'd1, 32'h103, 32'h0, rc, rd, e, wc, wcy, a1, rn);
        checks++;
`ifdef MISALIGN_TRAP_EN
        if (e !== 1'b1 || rc !== 1) begin
            errors++;
            $display("FAIL lh_misalign: err=%b cyc=%0d required 1 1", e, rc);
        end
`else
        if (e !== 1'b0 || rd !== 32'hFFFF_CAFE) begin
            errors++;
            $display("FAIL lh_misalign: err=%b data=%h required 0 ffffcafe", e, rd);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int rsp1, rsp2;
        logic [5:0] rdy;
        logic [31:0] d1, d2;
        rsp1 = 0; rsp2 = 0; rdy = 6'b0; d1 = 32'h0; d2 = 32'h0;
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h108; req_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            rdy[k-1] = req_ready;
            if (rsp_valid) begin
                if (rsp1 == 0) begin rsp1 = k; d1 = rsp_rdata; end
                else begin rsp2 = k; d2 = rsp_rdata; end
            end
            if (k == 5) req_valid = 1'b0;
        end
        checks++;
        if (rsp1 !== 2 || rsp2 !== 5 || d1 !== 32'hDEAD_BEEF || d2 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL b2b_rsp: cycles=%0d,%0d data=%h,%h required 2,5 deadbeef", rsp1, rsp2, d1, d2);
        end
        checks++;
        if (rdy !== 6'b100100) begin
            errors++;
            $display("FAIL b2b_ready: ready[6:1]=%b required 100100", rdy);
        end
    endtask

    task automatic test_reset_mid();
        int rn;
        int rc, wc, wcy, rn2; logic [31:0] rd, a1; logic e;
        rn = 0;
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h100; req_wdata = 32'h0000_0055; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL mid_we_before: mem_we=%b required 1", mem_we);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort: mem_we=%b rsp_valid=%b required 0 0", mem_we, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp_valid) rn++;
        end
        checks++;
        if (rn !== 0 || req_ready !== 1'b1 || mem[12'h040] !== 32'hCAFE_AABB) begin
            errors++;
            $display("FAIL mid_after: rsp=%0d ready=%b mem=%h required 0 1 cafeaabb", rn, req_ready, mem[12'h040]);
        end
        do_req(1'b0, 3'd2, 32'h100, 32'h0, rc, rd, e, wc, wcy, a1, rn2);
        checks++;
        if (rd !== 32'hCAFE_AABB || e !== 1'b0) begin
            errors++;
            $display("FAIL mid_readback: data=%h err=%b required cafeaabb 0", rd, e);
        end
    endtask

    initial begin
        mem[12'h040] = 32'h8899_AABB;
        mem[12'h041] = 32'h1122_3344;
        mem[12'h042] = 32'h0000_0000;
        test_reset();
        test_load();
        test_store_byte();
        test_store_half();
        test_store_word();
        test_errors();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
